sram_port_ctrl: RTL and testbench

- Initiator-side controller for one port of the team's dual-port SRAM wrapper. The wrapper has active-low enable/write-enable and 1-cycle synchronous read.
- Converts a valid/ready request stream (read/write) into SRAM port strobes.
- Captures read data one cycle after issue and returns it, in order, on a valid/ready response stream through a small response FIFO with credit-based backpressure.
- Two instances (port a, port b) sit between the DRRA memory-access logic and the sram wrapper.

---
 rtl/sram_port_ctrl.sv | 87 ++++++++
 tb/tb_sram_port_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_ctrl.sv
// Initiator-side controller for one port of the dual-port SRAM wrapper: turns a
// read/write request stream into active-low SRAM strobes and returns read data in order.
module sram_port_ctrl #(
    parameter int WIDTH      = 256,
    parameter int DEPTH      = 64,
    parameter int RESP_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [$clog2(DEPTH)-1:0] req_addr,
    input  logic [WIDTH-1:0]         req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_rdata,
    output logic                     sram_en_n,
    output logic                     sram_we_n,
    output logic [$clog2(DEPTH)-1:0] sram_addr,
    output logic [WIDTH-1:0]         sram_wdata,
    input  logic [WIDTH-1:0]         sram_q,
    output logic                     idle
);

    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = PW + 1;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high.
    // req_ready never looks at req_valid/req_write; rsp_valid never looks at rsp_ready.
    logic                  fire;
    logic                  pop;
    logic                  push;
    logic                  rd_pend;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW:0]           occupancy;
    logic [WIDTH-1:0]      mem [RESP_DEPTH];

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign push      = rd_pend;

    // Reserve a FIFO slot for every read in flight; a same-cycle pop frees one early.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, rd_pend} - {{CW{1'b0}}, pop};
    assign req_ready = rst_n & (occupancy < (CW+1)'(RESP_DEPTH));

    assign fire       = req_valid & req_ready;
    assign sram_en_n  = ~fire;
    assign sram_we_n  = ~(fire & req_write);
    assign sram_addr  = req_addr;
    assign sram_wdata = req_wdata;

    assign rsp_rdata = mem[rd_ptr];
    assign idle      = ~rd_pend & (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            rd_pend <= fire & ~req_write;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: contents behind an empty FIFO are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sram_q;
        end
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic checked against a transaction-level model of the port.
module tb_sram_port_ctrl;

    localparam int WIDTH      = 256;
    localparam int DEPTH      = 64;
    localparam int RESP_DEPTH = 2;
    localparam int AW         = $clog2(DEPTH);
    localparam int NVEC       = 20;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;
    logic             sram_en_n;
    logic             sram_we_n;
    logic [AW-1:0]    sram_addr;
    logic [WIDTH-1:0] sram_wdata;
    logic [WIDTH-1:0] sram_q;
    logic             idle;

    int n_checks;
    int n_fail;

    sram_port_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESP_DEPTH(RESP_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .sram_en_n  (sram_en_n),
        .sram_we_n  (sram_we_n),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_q     (sram_q),
        .idle       (idle)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM macro model (1-cycle synchronous read) ----------------
    logic [WIDTH-1:0] sram_mem    [DEPTH];
    logic [WIDTH-1:0] preload_val [DEPTH];
    logic             preload_go;

    always @(posedge clk) begin
        if (preload_go) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= preload_val[i];
        end else if (!sram_en_n) begin
            if (!sram_we_n) sram_mem[sram_addr] <= sram_wdata;
            else            sram_q <= sram_mem[sram_addr];
        end
    end

    // ---------------- check helpers ----------------
    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] rep8(input logic [7:0] b);
        return {(WIDTH/8){b}};
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] w;
        for (int k = 0; k < WIDTH/32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] ref_mem [DEPTH];

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;
    exp_t exp_q[$];
    int   cyc;
    logic prev_stall;
    logic [WIDTH-1:0] prev_data;

    // Starts and ends just after a rising edge; loads both the macro and the model.
    task automatic preload(input bit rnd);
        for (int i = 0; i < DEPTH; i++) begin
            preload_val[i] = rnd ? rand_word() : WIDTH'(i);
            ref_mem[i]     = preload_val[i];
        end
        preload_go = 1'b1;
        @(posedge clk); #1;
        preload_go = 1'b0;
    endtask

    // One cycle of model-based checking; inputs are already driven for this cycle.
    // A read fired in cycle c is deliverable from cycle c+2 on, strictly in order.
    task automatic model_cycle();
        logic exp_rv;
        logic pop_m;
        logic exp_rdy;
        exp_t e;
        @(negedge clk);
        exp_rv  = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
        pop_m   = exp_rv & rsp_ready;
        exp_rdy = ((exp_q.size() - int'(pop_m)) < RESP_DEPTH);
        chk1("rnd_rsp_valid", rsp_valid, exp_rv);
        chk1("rnd_req_ready", req_ready, exp_rdy);
        chk1("rnd_en_n", sram_en_n, ~(req_valid & exp_rdy));
        chk1("rnd_we_n", sram_we_n, ~(req_valid & exp_rdy & req_write));
        chk1("rnd_idle", idle, exp_q.size() == 0);
        chk1("rnd_count_bound", dut.count <= RESP_DEPTH, 1'b1);
        if (prev_stall) chkw("rnd_stall_stable", rsp_rdata, prev_data);
        if (pop_m) begin
            chkw("rnd_rdata", rsp_rdata, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        if (req_valid && exp_rdy) begin
            if (req_write) begin
                ref_mem[req_addr] = req_wdata;
            end else begin
                e.data = ref_mem[req_addr];
                e.cyc  = cyc;
                exp_q.push_back(e);
            end
        end
        prev_stall = rsp_valid & ~rsp_ready;
        prev_data  = rsp_rdata;
        cyc++;
        @(posedge clk); #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic             v;
        logic             w;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] wd;
        logic             rdy;
        logic             en_n;
        logic             we_n;
        logic             rv;
        logic             idl;
        logic [WIDTH-1:0] rdata;
    } vec_t;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic v, input logic w, input int addr,
                                input logic [WIDTH-1:0] wd, input logic rdy,
                                input logic en_n, input logic we_n, input logic rv,
                                input logic idl, input logic [WIDTH-1:0] rdata);
        vec_t r;
        r.v = v; r.w = w; r.addr = AW'(addr); r.wd = wd; r.rdy = rdy;
        r.en_n = en_n; r.we_n = we_n; r.rv = rv; r.idl = idl; r.rdata = rdata;
        return r;
    endfunction

    // ---------------- main sequence ----------------
    int fired_addr;
    int exp_val;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        preload_go = 1'b0;
        sram_q     = '0;
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;

        // Back-to-back reads of 0..7, then write/read of addr 3, then read-before-write of addr 5.
        for (int i = 0; i < 8; i++)
            tbl[i] = mk(1'b1, 1'b0, i, '0, 1'b1, 1'b0, 1'b1, i >= 2, i == 0, WIDTH'(i - 2));
        tbl[8]  = mk(1'b0, 1'b0, 0, '0,         1'b1, 1'b1, 1'b1, 1'b1, 1'b0, WIDTH'(6));
        tbl[9]  = mk(1'b0, 1'b0, 0, '0,         1'b1, 1'b1, 1'b1, 1'b1, 1'b0, WIDTH'(7));
        tbl[10] = mk(1'b1, 1'b1, 3, rep8(8'hA5), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        tbl[11] = mk(1'b1, 1'b0, 3, '0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0);
        tbl[12] = mk(1'b0, 1'b0, 0, '0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        tbl[13] = mk(1'b0, 1'b0, 0, '0,         1'b1, 1'b1, 1'b1, 1'b1, 1'b0, rep8(8'hA5));
        tbl[14] = mk(1'b1, 1'b0, 5, '0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0);
        tbl[15] = mk(1'b1, 1'b1, 5, rep8(8'hFF), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        tbl[16] = mk(1'b1, 1'b0, 5, '0,         1'b1, 1'b0, 1'b1, 1'b1, 1'b0, WIDTH'(5));
        tbl[17] = mk(1'b0, 1'b0, 0, '0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        tbl[18] = mk(1'b0, 1'b0, 0, '0,         1'b1, 1'b1, 1'b1, 1'b1, 1'b0, rep8(8'hFF));
        tbl[19] = mk(1'b0, 1'b0, 0, '0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0);

        // Reset state, with a request pending to show it is ignored.
        @(posedge clk); #1;
        preload(1'b0);
        @(negedge clk);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b0);
        chk1("rst_en_n", sram_en_n, 1'b1);
        chk1("rst_we_n", sram_we_n, 1'b1);
        chk1("rst_idle", idle, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int t = 0; t < NVEC; t++) begin
            req_valid = tbl[t].v;
            req_write = tbl[t].w;
            req_addr  = tbl[t].addr;
            req_wdata = tbl[t].wd;
            rsp_ready = 1'b1;
            @(negedge clk);
            chk1($sformatf("tbl%0d_req_ready", t), req_ready, tbl[t].rdy);
            chk1($sformatf("tbl%0d_en_n", t), sram_en_n, tbl[t].en_n);
            chk1($sformatf("tbl%0d_we_n", t), sram_we_n, tbl[t].we_n);
            chk1($sformatf("tbl%0d_rsp_valid", t), rsp_valid, tbl[t].rv);
            chk1($sformatf("tbl%0d_idle", t), idle, tbl[t].idl);
            if (tbl[t].rv) chkw($sformatf("tbl%0d_rdata", t), rsp_rdata, tbl[t].rdata);
            @(posedge clk); #1;
        end

        // Backpressure: only RESP_DEPTH reads accepted while rsp_ready is held low.
        rsp_ready  = 1'b0;
        req_write  = 1'b0;
        fired_addr = 8;
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1;
            req_addr  = AW'(fired_addr);
            @(negedge clk);
            chk1($sformatf("stall%0d_req_ready", k), req_ready, k < RESP_DEPTH);
            chk1($sformatf("stall%0d_en_n", k), sram_en_n, k >= RESP_DEPTH);
            if (req_ready) fired_addr++;
            @(posedge clk); #1;
        end
        chki("stall_accepted", fired_addr - 8, RESP_DEPTH);
        rsp_ready = 1'b1;
        exp_val   = 8;
        for (int k = 0; k < 12; k++) begin
            req_valid = (k < 8);
            req_addr  = AW'(fired_addr);
            @(negedge clk);
            if (k < 8) chk1($sformatf("resume%0d_req_ready", k), req_ready, 1'b1);
            if (rsp_valid) begin
                chkw($sformatf("resume_rdata%0d", exp_val), rsp_rdata, WIDTH'(exp_val));
                exp_val++;
            end
            if (req_valid && req_ready) fired_addr++;
            @(posedge clk); #1;
        end
        chki("resume_fired", fired_addr, 18);
        chki("resume_returned", exp_val, 18);

        // Reset in the cycle after a read fire: that read must vanish.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = AW'(2);
        @(negedge clk);
        chk1("mid_fire_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        rst_n    = 1'b0;
        req_addr = AW'(4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1($sformatf("midrst%0d_rsp_valid", k), rsp_valid, 1'b0);
            chk1($sformatf("midrst%0d_req_ready", k), req_ready, 1'b0);
            chk1($sformatf("midrst%0d_en_n", k), sram_en_n, 1'b1);
            chk1($sformatf("midrst%0d_we_n", k), sram_we_n, 1'b1);
            chk1($sformatf("midrst%0d_idle", k), idle, 1'b1);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_ready", req_ready, 1'b1);
        chk1("post_rst_en_n", sram_en_n, 1'b0);
        chk1("post_rst_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk1("post_rst_rv_1", rsp_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("post_rst_rv_2", rsp_valid, 1'b1);
        chkw("post_rst_rdata", rsp_rdata, WIDTH'(4));
        @(posedge clk); #1;
        @(negedge clk);
        chk1("post_rst_idle", idle, 1'b1);
        @(posedge clk); #1;

        // Random traffic against the model, with varying consumer backpressure.
        preload(1'b1);
        for (int c = 0; c < 10000; c++) begin
            int rr_pct;
            case ((c / 500) % 4)
                0:       rr_pct = 100;
                1:       rr_pct = 50;
                2:       rr_pct = 10;
                default: rr_pct = 85;
            endcase
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = ($urandom_range(0, 2) == 0);
            req_addr  = AW'($urandom_range(0, DEPTH - 1));
            req_wdata = rand_word();
            rsp_ready = ($urandom_range(0, 99) < rr_pct);
            model_cycle();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) model_cycle();
        chki("drain_outstanding", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
